// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: combinational hit path, whole-block refill over a
// busywait handshake, synchronous flush and saturating hit/miss counters.
module icache_direct_mapped #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  parameter int ADDR_W          = 10,
  parameter int CNT_W           = 16
) (
  input  logic                                          CLOCK,
  input  logic                                          RESET,
  input  logic [ADDR_W-1:0]                             PC,
  input  logic                                          request,
  input  logic                                          flush,
  output logic [WORD_W-1:0]                             instruction,
  output logic                                          busywait,
  output logic                                          mem_read,
  output logic [ADDR_W-3-$clog2(WORDS_PER_BLOCK):0]     mem_address,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0]             mem_readdata,
  input  logic                                          mem_busywait,
  output logic [CNT_W-1:0]                              hit_count,
  output logic [CNT_W-1:0]                              miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int BLK_W = WORD_W * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_r, state_s;
  logic [NUM_SETS-1:0] valid_r;
  logic [TAG_W-1:0]    tag_r  [NUM_SETS];
  logic [BLK_W-1:0]    data_r [NUM_SETS];
  logic [BLK_W-1:0]    buf_r;
  logic [TAG_W-1:0]    miss_tag_r;
  logic [IDX_W-1:0]    miss_idx_r;
  logic [CNT_W-1:0]    hit_cnt_r, miss_cnt_r;

  logic [OFF_W-1:0]    off_s;
  logic [IDX_W-1:0]    idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic [BLK_W-1:0]    line_s;
  logic                hit_s, miss_s;
  logic                unused_s;

  assign off_s    = PC[2 +: OFF_W];
  assign idx_s    = PC[2+OFF_W +: IDX_W];
  assign tag_s    = PC[ADDR_W-1 -: TAG_W];
  assign unused_s = ^PC[1:0];
  assign line_s   = data_r[idx_s];

  assign hit_s  = request & valid_r[idx_s] & (tag_r[idx_s] == tag_s) & (state_r == IDLE);
  assign miss_s = request & ~hit_s & (state_r == IDLE);

  assign instruction = hit_s ? line_s[off_s*WORD_W +: WORD_W] : {WORD_W{1'b0}};
  assign hit_count   = hit_cnt_r;
  assign miss_count  = miss_cnt_r;

  // Next-state and handshake decode; the memory only ever sees the latched miss address
  always_comb begin
    state_s     = state_r;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_r)
      IDLE: begin
        busywait = request & ~hit_s;
        if (miss_s) begin
          state_s = MEM_READ;
        end else begin
          state_s = IDLE;
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag_r, miss_idx_r};
        if (!mem_busywait) begin
          state_s = UPDATE;
        end else begin
          state_s = MEM_READ;
        end
      end
      UPDATE: begin
        busywait = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, miss-address latch, refill buffer and statistics counters
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= IDLE;
      miss_tag_r <= '0;
      miss_idx_r <= '0;
      buf_r      <= '0;
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if (miss_s) begin
        miss_tag_r <= tag_s;
        miss_idx_r <= idx_s;
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
      if (hit_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end
      if ((state_r == MEM_READ) && !mem_busywait) begin
        buf_r <= mem_readdata;
      end
    end
  end

  // Valid bits: the refilled line is set after the flush clear so it survives a same-edge flush
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      valid_r <= '0;
    end else begin
      if (flush) begin
        valid_r <= '0;
      end
      if (state_r == UPDATE) begin
        valid_r[miss_idx_r] <= 1'b1;
      end
    end
  end

  // Tag and data arrays, written once per refill on the UPDATE exit edge
  always_ff @(posedge CLOCK) begin
    if (state_r == UPDATE) begin
      tag_r[miss_idx_r]  <= miss_tag_r;
      data_r[miss_idx_r] <= buf_r;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: reference tag/valid model, behavioural
// block memory, and a second CNT_W=2 instance for counter saturation.
module tb_icache_direct_mapped;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        RESET;
  logic [9:0]  pc;
  logic        request, flush;
  logic [31:0] instruction;
  logic        busywait, mem_read, mem_busywait;
  logic [5:0]  mem_address;
  logic [127:0] mem_readdata;
  logic [15:0] hit_count, miss_count;
  int          mcnt = 0;

  logic [9:0]  pc2;
  logic        request2, flush2;
  logic [31:0] instruction2;
  logic        busywait2, mem_read2, mem_busywait2;
  logic [5:0]  mem_address2;
  logic [127:0] mem_readdata2;
  logic [1:0]  hit_count2, miss_count2;
  logic        mr2_d = 1'b0;

  int vectors = 0, miscompares = 0;
  int exp_hits = 0, exp_misses = 0;
  logic [31:0] exp_q[$];
  bit          m_valid [8];
  logic [2:0]  m_tag   [8];

  always #5 clk = ~clk;

  icache_direct_mapped dut (
    .CLOCK(clk), .RESET(RESET), .PC(pc), .request(request), .flush(flush),
    .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_direct_mapped #(.CNT_W(2)) dut2 (
    .CLOCK(clk), .RESET(RESET), .PC(pc2), .request(request2), .flush(flush2),
    .instruction(instruction2), .busywait(busywait2), .mem_read(mem_read2),
    .mem_address(mem_address2), .mem_readdata(mem_readdata2), .mem_busywait(mem_busywait2),
    .hit_count(hit_count2), .miss_count(miss_count2)
  );

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input int k);
    return (32'(blk) << 8) | 32'((k + 1) * 17);
  endfunction

  // Memory stays busy for LAT-1 cycles of mem_read, so MEM_READ lasts LAT cycles
  always @(posedge clk) mcnt <= mem_read ? mcnt + 1 : 0;
  assign mem_busywait = mem_read && (mcnt < LAT - 1);
  always @(posedge clk) mr2_d <= mem_read2;
  assign mem_busywait2 = mem_read2 & ~mr2_d;

  always_comb begin
    mem_readdata  = '0;
    mem_readdata2 = '0;
    for (int k = 0; k < 4; k++) begin
      mem_readdata[k*32 +: 32]  = mem_word(mem_address, k);
      mem_readdata2[k*32 +: 32] = mem_word(mem_address2, k);
    end
  end

  // One fetch from posedge+1: expected word queued now, popped when busywait drops
  task automatic fetch(input logic [9:0] a, input int flush_at);
    int busy;
    bit hit, seen;
    logic [5:0]  seen_addr;
    logic [31:0] exp_w, got;
    hit = m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
    exp_q.push_back(mem_word(a[9:4], int'(a[3:2])));
    pc = a; request = 1'b1; busy = 0; seen = 1'b0; seen_addr = '0;
    forever begin
      @(negedge clk);
      if (!busywait) break;
      if (busy == 0) begin
        vectors++;
        if (instruction !== 32'h0) begin
          miscompares++;
          $display("FAIL miss_instr pc=%h got %h want 0", a, instruction);
        end
      end
      if (mem_read && !seen) begin seen = 1'b1; seen_addr = mem_address; end
      busy++;
      if (busy > 40) begin
        vectors++; miscompares++;
        $display("FAIL timeout pc=%h busywait never dropped", a);
        break;
      end
      @(posedge clk); #1;
      flush = (busy == flush_at);
    end
    got = instruction;
    exp_w = exp_q.pop_front();
    vectors++;
    if (got !== exp_w) begin
      miscompares++;
      $display("FAIL instr pc=%h got %h want %h", a, got, exp_w);
    end
    vectors++;
    if (busy != (hit ? 0 : LAT + 2)) begin
      miscompares++;
      $display("FAIL stall pc=%h got %0d want %0d", a, busy, hit ? 0 : LAT + 2);
    end
    if (!hit) begin
      vectors++;
      if (seen_addr !== a[9:4]) begin
        miscompares++;
        $display("FAIL mem_address pc=%h got %h want %h", a, seen_addr, a[9:4]);
      end
      exp_misses++;
      if (flush_at >= 0) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]] = a[9:7];
    end
    exp_hits++;
    @(posedge clk); #1;
    request = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; request = 1'b1; pc = 10'h000; flush = 1'b0;
    request2 = 1'b0; pc2 = 10'h000; flush2 = 1'b0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = 3'd0; end
    @(negedge clk);
    vectors++;
    if (instruction !== 32'h0 || busywait !== 1'b1 || mem_read !== 1'b0 ||
        hit_count !== 16'd0 || miss_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got instr=%h bw=%b mr=%b h=%0d m=%0d want 0/1/0/0/0",
               instruction, busywait, mem_read, hit_count, miss_count);
    end
    RESET = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL enter_mem_read got mem_read=%b want 1", mem_read);
    end
    #2 RESET = 1'b0;
    #1;
    vectors++;
    if (mem_read !== 1'b0 || miss_count !== 16'd0 || busywait !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_abort got mr=%b m=%0d bw=%b want 0/0/1", mem_read, miss_count, busywait);
    end
    request = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    #1 request = 1'b1;
    #1;
    vectors++;
    if (busywait !== 1'b1 || instruction !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_miss got bw=%b instr=%h want 1/0", busywait, instruction);
    end
    request = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_and_hits();
    fetch(10'h000, -1);
    vectors++;
    if (miss_count !== 16'd1) begin
      miscompares++;
      $display("FAIL cold_miss_count got %0d want 1", miss_count);
    end
    fetch(10'h004, -1);
    fetch(10'h008, -1);
    fetch(10'h00C, -1);
    vectors++;
    if (hit_count !== 16'd4) begin
      miscompares++;
      $display("FAIL seq_hit_count got %0d want 4", hit_count);
    end
  endtask

  task automatic test_conflict();
    fetch(10'h080, -1);
    fetch(10'h000, -1);
    vectors++;
    if (miss_count !== 16'd3) begin
      miscompares++;
      $display("FAIL conflict_miss_count got %0d want 3", miss_count);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    fetch(10'h004, -1);
    fetch(10'h020, 2);
    fetch(10'h024, -1);
    fetch(10'h000, -1);
    fetch(10'h030, 6);
    fetch(10'h034, -1);
    fetch(10'h000, -1);
  endtask

  task automatic test_back_to_back();
    fetch(10'h004, -1);
    fetch(10'h100, -1);
    fetch(10'h038, -1);
    fetch(10'h108, -1);
    fetch(10'h3FC, -1);
    fetch(10'h3F0, -1);
    vectors++;
    if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
      miscompares++;
      $display("FAIL counters got h=%0d m=%0d want h=%0d m=%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_saturation();
    int hits;
    hits = 0;
    pc2 = 10'h000; request2 = 1'b1;
    for (int i = 0; i < 30 && hits < 6; i++) begin
      @(negedge clk);
      if (!busywait2) begin
        vectors++;
        if (hit_count2 !== 2'((hits > 3) ? 3 : hits) || instruction2 !== 32'h11) begin
          miscompares++;
          $display("FAIL sat_step%0d got h=%0d instr=%h want h=%0d instr=11",
                   hits, hit_count2, instruction2, (hits > 3) ? 3 : hits);
        end
        hits++;
      end
    end
    @(posedge clk); #1;
    request2 = 1'b0;
    @(negedge clk);
    vectors++;
    if (hits != 6 || hit_count2 !== 2'd3 || miss_count2 !== 2'd1) begin
      miscompares++;
      $display("FAIL saturation got hits=%0d h=%0d m=%0d want 6/3/1", hits, hit_count2, miss_count2);
    end
  endtask

  initial begin
    test_reset();
    test_cold_and_hits();
    test_conflict();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
